dut_mac_18x18_seq: RTL and testbench

//  Sequential multiply-accumulate front/back end for dut_multiplier_18x18_comb.
//  - Upstream: accepts 18-bit unsigned operand pairs over a valid/ready handshake.
//  - Registers each pair and drives it into one dut_multiplier_18x18_comb instance.
//  - Downstream: accumulates the 36-bit products into a dot-product result.
//  - Presents the result over a valid/ready handshake.

---
 rtl/dut_mac_18x18_seq.sv | 141 ++++++++++++++
 tb/tb_dut_mac_18x18_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dut_mac_18x18_seq.sv
// Sequential 18x18 multiply-accumulate: valid/ready operand beats are registered,
// multiplied, summed into a dot product and presented once per frame.

module dut_multiplier_18x18_comb (
    input  logic [17:0] a_i,
    input  logic [17:0] b_i,
    output logic [35:0] prod_o
);
    assign prod_o = 36'(a_i) * 36'(b_i);
endmodule

module dut_mac_18x18_seq #(
    parameter  int unsigned ACC_W = 48,
    parameter  int unsigned LEN   = 8,
    localparam int unsigned CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_beats,
    input  logic             VDD,
    input  logic             VSS
);
    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [17:0]        a_q, b_q;
    logic               s1_valid_q, s1_last_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [35:0]        prod;
    logic [ACC_W:0]     sum_c;
    logic               in_fire, out_fire, beat_last_c;
    logic               unused_pwr;

    assign unused_pwr  = VDD ^ VSS;
    assign in_fire     = in_valid & in_ready_q;
    assign out_fire    = out_valid_q & out_ready;
    assign beat_last_c = in_last | (cnt_q == CNT_W'(LEN - 1));

    dut_multiplier_18x18_comb u_mul (
        .a_i    (a_q),
        .b_i    (b_q),
        .prod_o (prod)
    );

    // Extra top bit captures the carry out of the accumulator.
    assign sum_c = {1'b0, acc_q} + {1'b0, ACC_W'(prod)};

    // S1 operand stage
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= in_fire;
            if (in_fire) begin
                a_q       <= in_a;
                b_q       <= in_b;
                s1_last_q <= beat_last_c;
            end
        end
    end

    // State, accumulator and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCEPT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state, accumulate and frame bookkeeping
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (s1_valid_q) begin
            acc_d = sum_c[ACC_W-1:0];
            ovf_d = ovf_q | sum_c[ACC_W];
        end
        case (state_q)
            ST_ACCEPT: begin
                if (in_fire) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (beat_last_c) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (s1_valid_q && s1_last_q) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_fire) begin
                    state_d = ST_ACCEPT;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
        in_ready_d  = (state_d == ST_ACCEPT);
        out_valid_d = (state_d == ST_HOLD);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_ovf   = ovf_q;
    assign out_beats = cnt_q;

endmodule

// File: tb/tb_dut_mac_18x18_seq.sv
// Directed and randomised-gap checks of dut_mac_18x18_seq (ACC_W=36, LEN=4).

module tb_dut_mac_18x18_seq;
    localparam int unsigned ACC_W = 36;
    localparam int unsigned LEN   = 4;
    localparam int unsigned CNT_W = $clog2(LEN + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [17:0]      in_a, in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;
    logic [CNT_W-1:0] out_beats;

    int n_cmp = 0;
    int n_err = 0;

    dut_mac_18x18_seq #(.ACC_W(ACC_W), .LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_beats (out_beats),
        .VDD       (1'b1),
        .VSS       (1'b0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until the DUT takes it.
    task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
        int   t;
        logic took;
        t        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        do begin
            took = in_ready;
            step();
            t++;
        end while (!took && t < 200);
        if (!took) check("send_timeout", 64'(took), 64'd1);
    endtask

    task automatic get_result(output logic [ACC_W-1:0] d, output logic ovf,
                              output logic [CNT_W-1:0] beats);
        int t;
        t         = 0;
        out_ready = 1'b1;
        while (!out_valid && t < 200) begin
            step();
            t++;
        end
        check("result_valid", 64'(out_valid), 64'd1);
        d     = out_data;
        ovf   = out_ovf;
        beats = out_beats;
        step();
        out_ready = 1'b0;
        check("no_extra_result", 64'(out_valid), 64'd0);
    endtask

    function automatic logic [17:0] pick();
        if ($urandom_range(0, 3) == 0) return 18'h3FFFF;
        return 18'($urandom);
    endfunction

    logic [ACC_W-1:0] r_data;
    logic             r_ovf;
    logic [CNT_W-1:0] r_beats;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
        step(); step();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'd0);
        check("rst_out_beats", 64'(out_beats), 64'd0);
        rst = 1'b0;

        // Reset mid-frame drops partial state
        send(18'd1, 18'd1, 1'b0);
        send(18'd2, 18'd2, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_out_beats", 64'(out_beats), 64'd0);
        send(18'd2, 18'd3, 1'b0);
        send(18'd4, 18'd5, 1'b1);
        in_valid = 1'b0;
        get_result(r_data, r_ovf, r_beats);
        check("after_rst_data", 64'(r_data), 64'd26);
        check("after_rst_beats", 64'(r_beats), 64'd2);

        // Full-length frame ended by the beat cap, with latency checks
        out_ready = 1'b1;
        send(18'd3, 18'd3, 1'b0);
        send(18'd5, 18'd5, 1'b0);
        send(18'd1, 18'd2, 1'b0);
        send(18'd4, 18'd0, 1'b0);
        in_valid = 1'b0;
        check("len_e0_out_valid", 64'(out_valid), 64'd0);
        check("len_e0_in_ready", 64'(in_ready), 64'd0);
        step();
        check("len_e1_out_valid", 64'(out_valid), 64'd1);
        check("len_data", 64'(out_data), 64'd36);
        check("len_beats", 64'(out_beats), 64'd4);
        check("len_ovf", 64'(out_ovf), 64'd0);
        step();
        check("len_done_out_valid", 64'(out_valid), 64'd0);
        check("len_done_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b0;

        // Single-beat frame at maximum operands
        send(18'h3FFFF, 18'h3FFFF, 1'b1);
        in_valid = 1'b0;
        get_result(r_data, r_ovf, r_beats);
        check("one_data", 64'(r_data), 64'hF_FFF8_0001);
        check("one_beats", 64'(r_beats), 64'd1);
        check("one_ovf", 64'(r_ovf), 64'd0);

        // Accumulator wrap sets sticky overflow, cleared for the next frame
        send(18'h3FFFF, 18'h3FFFF, 1'b0);
        send(18'h3FFFF, 18'h3FFFF, 1'b1);
        in_valid = 1'b0;
        get_result(r_data, r_ovf, r_beats);
        check("wrap_data", 64'(r_data), 64'hF_FFF0_0002);
        check("wrap_ovf", 64'(r_ovf), 64'd1);
        check("wrap_beats", 64'(r_beats), 64'd2);
        send(18'd1, 18'd1, 1'b1);
        in_valid = 1'b0;
        get_result(r_data, r_ovf, r_beats);
        check("postwrap_data", 64'(r_data), 64'd1);
        check("postwrap_ovf", 64'(r_ovf), 64'd0);

        // Output backpressure with the next beat already waiting
        out_ready = 1'b0;
        send(18'd7, 18'd8, 1'b1);
        in_a = 18'd9; in_b = 18'd9; in_last = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_data", 64'(out_data), 64'd56);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        send(18'd9, 18'd9, 1'b1);
        in_valid = 1'b0;
        get_result(r_data, r_ovf, r_beats);
        check("bp_next_data", 64'(r_data), 64'd81);
        check("bp_next_beats", 64'(r_beats), 64'd1);

        // Random frames with valid and ready gaps against a reference sum
        for (int f = 0; f < 1000; f++) begin
            int unsigned nb;
            logic [63:0] macc;
            logic        movf;
            nb   = $urandom_range(1, LEN);
            macc = '0;
            movf = 1'b0;
            for (int k = 0; k < int'(nb); k++) begin
                logic [17:0] a, b;
                logic        last;
                int unsigned gap;
                a    = pick();
                b    = pick();
                last = (k == int'(nb) - 1) ? ((nb == LEN) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
                gap  = $urandom_range(0, 2);
                in_valid = 1'b0;
                for (int g = 0; g < int'(gap); g++) step();
                send(a, b, last);
                macc = macc + 64'(a) * 64'(b);
                if (macc >= 64'h10_0000_0000) begin
                    macc = macc - 64'h10_0000_0000;
                    movf = 1'b1;
                end
            end
            in_valid = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
            get_result(r_data, r_ovf, r_beats);
            check("rnd_data", 64'(r_data), macc);
            check("rnd_ovf", 64'(r_ovf), 64'(movf));
            check("rnd_beats", 64'(r_beats), 64'(nb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
